// File: rtl/breakout_pkg.sv
// Shared timing defaults and channel-mode encoding for the game timer.
package breakout_pkg;

    localparam int unsigned DEF_PERIOD_RST  = 250_000;
    localparam int unsigned DEF_PERIOD_MIN  = 50_000;
    localparam int unsigned DEF_PERIOD_STEP = 10_000;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } chan_mode_t;

endpackage

// File: rtl/game_timer_chan.sv
// One timer channel: counter, period register, mode and running flag.
module game_timer_chan
    import breakout_pkg::*;
#(
    parameter int unsigned   CW          = 31,
    parameter logic [CW-1:0] PERIOD_RST  = CW'(DEF_PERIOD_RST),
    parameter logic [CW-1:0] PERIOD_MIN  = CW'(DEF_PERIOD_MIN),
    parameter logic [CW-1:0] PERIOD_STEP = CW'(DEF_PERIOD_STEP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          oneshot,
    input  logic          speedup,
    input  logic          load,
    input  logic [CW-1:0] load_period,
    output logic          pulse,
    output logic          running,
    output logic [CW-1:0] period
);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] period_nxt;
    logic [CW-1:0] period_sped;
    logic          running_nxt;
    logic          wrap;
    chan_mode_t    mode;
    chan_mode_t    mode_nxt;

    // Tick is combinational from the counter so it lands in the wrap cycle.
    assign wrap  = running && (count == period);
    assign pulse = wrap;

    // Reduced period, floored at the minimum and safe against underflow.
    always_comb begin
        period_sped = PERIOD_MIN;
        if ((period >= PERIOD_STEP) && ((period - PERIOD_STEP) > PERIOD_MIN))
            period_sped = period - PERIOD_STEP;
    end

    // Next-state: count/wrap, then stop > start, speedup clamp, load last.
    always_comb begin
        count_nxt   = count;
        period_nxt  = period;
        running_nxt = running;
        mode_nxt    = mode;

        if (running) begin
            count_nxt = wrap ? '0 : count + CW'(1);
            if (wrap && (mode == MODE_ONESHOT))
                running_nxt = 1'b0;
        end

        if (stop) begin
            running_nxt = 1'b0;
            count_nxt   = count;
        end else if (start) begin
            running_nxt = 1'b1;
            count_nxt   = '0;
            mode_nxt    = oneshot ? MODE_ONESHOT : MODE_PERIODIC;
        end

        // A counter already past the shortened period restarts silently.
        if (speedup) begin
            period_nxt = period_sped;
            if (period_sped < count_nxt)
                count_nxt = '0;
        end

        if (load) begin
            period_nxt = load_period;
            count_nxt  = '0;
        end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            period  <= PERIOD_RST;
            running <= 1'b0;
            mode    <= MODE_PERIODIC;
        end else begin
            count   <= count_nxt;
            period  <= period_nxt;
            running <= running_nxt;
            mode    <= mode_nxt;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Multi-channel game timer: load decode and output packing around NCH channels.
module game_timer
    import breakout_pkg::*;
#(
    parameter int unsigned   NCH         = 4,
    parameter int unsigned   CW          = 31,
    parameter logic [CW-1:0] PERIOD_RST  = CW'(DEF_PERIOD_RST),
    parameter logic [CW-1:0] PERIOD_MIN  = CW'(DEF_PERIOD_MIN),
    parameter logic [CW-1:0] PERIOD_STEP = CW'(DEF_PERIOD_STEP),
    localparam int unsigned  LW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH-1:0]    oneshot,
    input  logic [NCH-1:0]    speedup,
    input  logic              load_valid,
    input  logic [LW-1:0]     load_ch,
    input  logic [CW-1:0]     load_period,
    output logic [NCH-1:0]    pulse,
    output logic [NCH-1:0]    running,
    output logic [NCH*CW-1:0] period
);

    // Per-channel instances; an out-of-range load_ch matches no channel.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic load_hit;

        assign load_hit = load_valid && (load_ch == LW'(i));

        game_timer_chan #(
            .CW          (CW),
            .PERIOD_RST  (PERIOD_RST),
            .PERIOD_MIN  (PERIOD_MIN),
            .PERIOD_STEP (PERIOD_STEP)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .start       (start[i]),
            .stop        (stop[i]),
            .oneshot     (oneshot[i]),
            .speedup     (speedup[i]),
            .load        (load_hit),
            .load_period (load_period),
            .pulse       (pulse[i]),
            .running     (running[i]),
            .period      (period[i*CW +: CW])
        );
    end

endmodule
